// File: rtl/rv_regfile_pkg.sv
// Shared widths, the write-request record and arbiter state names for the
// regfile write-port arbiter and its scoreboard.
package rv_regfile_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wr_req_t;

  typedef enum logic [0:0] {
    A_PRIO  = 1'b0,
    B_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy vector for registers with an outstanding long-latency write.
// x0 is never busy; a set and a clear on the same register in one cycle leaves it busy.
module regfile_scoreboard
  import rv_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] look1_addr,
  output logic                  look1_busy,
  input  logic [REG_ADDR_W-1:0] look2_addr,
  output logic                  look2_busy
);

  logic [NUM_REGS-1:0] busy_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign busy_vec[gi] = 1'b0;
      end else begin : g_live
        logic bit_reg;
        logic hit_set;
        logic hit_clr;

        assign hit_set = set_en & (set_addr == REG_ADDR_W'(gi));
        assign hit_clr = clr_en & (clr_addr == REG_ADDR_W'(gi));

        always_ff @(posedge clk) begin
          if (rst) begin
            bit_reg <= 1'b0;
          end else if (hit_set) begin
            bit_reg <= 1'b1;
          end else if (hit_clr) begin
            bit_reg <= 1'b0;
          end
        end

        assign busy_vec[gi] = bit_reg;
      end
    end
  endgenerate

  assign look1_busy = busy_vec[look1_addr];
  assign look2_busy = busy_vec[look2_addr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between in-order writeback (A) and
// the long-latency unit (B), with starvation relief for B and decode hazard flags.
module regfile_wb_arbiter
  import rv_regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wa_valid,
  output logic                  wa_ready,
  input  logic [REG_ADDR_W-1:0] wa_addr,
  input  logic [XLEN-1:0]       wa_data,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  sb_set,
  input  logic [REG_ADDR_W-1:0] sb_set_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  rd_wren,
  output logic [XLEN-1:0]       rd_data
);

  localparam int              CNT_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [0:0]      S_A_PRIO  = A_PRIO;
  localparam logic [0:0]      S_B_FORCE = B_FORCE;

  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] starve_reg, starve_next, starve_inc;
  wr_req_t          out_req_reg, out_req_next, win_req;
  logic             rd_wren_reg, rd_wren_next;
  logic             a_acc, b_acc;
  logic             sb_busy1, sb_busy2;

  always_comb begin
    wa_ready = (state_reg == S_A_PRIO);
    wb_ready = (state_reg == S_B_FORCE) | ~wa_valid;
    a_acc    = wa_valid & wa_ready;
    b_acc    = wb_valid & wb_ready;
  end

  // Only refused B cycles in A_PRIO count; the forced cycle itself always resets the count.
  always_comb begin
    state_next  = S_A_PRIO;
    starve_next = '0;
    starve_inc  = starve_reg + CNT_W'(1);
    if (state_reg == S_A_PRIO && wb_valid && !wb_ready) begin
      if (starve_inc == CNT_LIMIT) begin
        state_next = S_B_FORCE;
      end else begin
        starve_next = starve_inc;
      end
    end
  end

  always_comb begin
    win_req.addr = a_acc ? wa_addr : wb_addr;
    win_req.data = a_acc ? wa_data : wb_data;
    rd_wren_next = (a_acc | b_acc) & (win_req.addr != '0);
    out_req_next = (a_acc | b_acc) ? win_req : out_req_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_A_PRIO;
      starve_reg  <= '0;
      out_req_reg <= '0;
      rd_wren_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      starve_reg  <= starve_next;
      out_req_reg <= out_req_next;
      rd_wren_reg <= rd_wren_next;
    end
  end

  regfile_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (sb_set),
    .set_addr   (sb_set_addr),
    .clr_en     (b_acc),
    .clr_addr   (wb_addr),
    .look1_addr (rs1_addr),
    .look1_busy (sb_busy1),
    .look2_addr (rs2_addr),
    .look2_busy (sb_busy2)
  );

  // The regfile does not bypass, so the register being written this cycle is still stale.
  always_comb begin
    rs1_busy = (rs1_addr != '0) & (sb_busy1 | (rd_wren_reg & (out_req_reg.addr == rs1_addr)));
    rs2_busy = (rs2_addr != '0) & (sb_busy2 | (rd_wren_reg & (out_req_reg.addr == rs2_addr)));
  end

  assign rd_addr = out_req_reg.addr;
  assign rd_data = out_req_reg.data;
  assign rd_wren = rd_wren_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized checks of regfile_wb_arbiter against a cycle-level
// reference model of the arbitration, scoreboard and hazard rules.
module tb_regfile_wb_arbiter;
  import rv_regfile_pkg::*;

  localparam int LIMIT = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wa_valid, wa_ready;
  logic [REG_ADDR_W-1:0] wa_addr;
  logic [XLEN-1:0]       wa_data;
  logic                  wb_valid, wb_ready;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]       wb_data;
  logic                  sb_set;
  logic [REG_ADDR_W-1:0] sb_set_addr;
  logic [REG_ADDR_W-1:0] rs1_addr, rs2_addr;
  logic                  rs1_busy, rs2_busy;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic                  rd_wren;
  logic [XLEN-1:0]       rd_data;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .wa_valid    (wa_valid),
    .wa_ready    (wa_ready),
    .wa_addr     (wa_addr),
    .wa_data     (wa_data),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .sb_set      (sb_set),
    .sb_set_addr (sb_set_addr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rd_addr     (rd_addr),
    .rd_wren     (rd_wren),
    .rd_data     (rd_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: registers awaiting a B write, refused-B streak, pending forced grant,
  // and the write the regfile sees on the next edge.
  bit          m_busy [NUM_REGS];
  int          m_streak;
  bit          m_force;
  bit          m_wren;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  function automatic void model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 1'b0;
    m_streak = 0;
    m_force  = 1'b0;
    m_wren   = 1'b0;
    m_addr   = '0;
    m_data   = '0;
  endfunction

  function automatic bit exp_busy(input logic [4:0] a);
    return (a != 0) && (m_busy[a] || (m_wren && m_addr == a));
  endfunction

  task automatic idle();
    wa_valid = 1'b0; wa_addr = '0; wa_data = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    sb_set = 1'b0; sb_set_addr = '0;
    rs1_addr = '0; rs2_addr = '0;
  endtask

  // Called at a negedge with inputs set; checks, advances the model, returns at the next negedge.
  task automatic cycle();
    bit exp_wa, exp_wb, a, b;
    #1;
    exp_wa = !m_force;
    exp_wb = m_force || !wa_valid;
    check("wa_ready", wa_ready, exp_wa);
    check("wb_ready", wb_ready, exp_wb);
    check("rd_wren", rd_wren, m_wren);
    if (m_wren) begin
      check("rd_addr", rd_addr, m_addr);
      check("rd_data", rd_data, m_data);
    end
    check("rs1_busy", rs1_busy, exp_busy(rs1_addr));
    check("rs2_busy", rs2_busy, exp_busy(rs2_addr));

    a = wa_valid && exp_wa;
    b = wb_valid && exp_wb;
    if (a) begin
      m_wren = (wa_addr != 0); m_addr = wa_addr; m_data = wa_data;
      $display("txn port=A addr=%0d data=%h", wa_addr, wa_data);
    end else if (b) begin
      m_wren = (wb_addr != 0); m_addr = wb_addr; m_data = wb_data;
      $display("txn port=B addr=%0d data=%h", wb_addr, wb_data);
    end else begin
      m_wren = 1'b0;
    end
    if (b) m_busy[wb_addr] = 1'b0;
    if (sb_set && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
    if (m_force) begin
      m_force = 1'b0;
      m_streak = 0;
    end else if (wb_valid && !b) begin
      m_streak++;
      if (m_streak >= LIMIT) begin
        m_force = 1'b1;
        m_streak = 0;
      end
    end else begin
      m_streak = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_state();
    rs1_addr = 5'd5; rs2_addr = 5'd3;
    #1;
    check("rst_rd_wren", rd_wren, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rs1_busy", rs1_busy, 0);
    check("rst_rs2_busy", rs2_busy, 0);
  endtask

  bit t3_pat [7] = '{1, 1, 1, 1, 0, 1, 1};

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_state();
    idle();

    // Port A write; hazard visible only in the write cycle
    wa_valid = 1; wa_addr = 5'd1; wa_data = 32'hAAAABBBB; rs1_addr = 5'd1;
    cycle();
    idle(); rs1_addr = 5'd1;
    check("t2_rs1_busy_inflight", rs1_busy, 1);
    cycle();
    rs1_addr = 5'd1;
    cycle();

    // Both ports held: B forced through after LIMIT refusals
    for (int i = 0; i < 7; i++) begin
      wa_valid = 1; wa_addr = 5'd10 + 5'(i); wa_data = 32'h1000 + i;
      wb_valid = 1; wb_addr = 5'd20; wb_data = 32'hB0B0B0B0;
      #1;
      check("t3_wa_ready", wa_ready, t3_pat[i]);
      cycle();
    end
    idle(); cycle();

    // Scoreboard set, B write clears it, in-flight hazard covers the write cycle
    sb_set = 1; sb_set_addr = 5'd3;
    cycle();
    idle(); rs2_addr = 5'd3;
    cycle();
    wb_valid = 1; wb_addr = 5'd3; wb_data = 32'h12345678; rs2_addr = 5'd3;
    cycle();
    idle(); rs2_addr = 5'd3;
    check("t4_rs2_busy_write", rs2_busy, 1);
    cycle();
    rs2_addr = 5'd3;
    check("t4_rs2_busy_done", rs2_busy, 0);
    cycle();

    // x0 writes and sets have no effect
    wb_valid = 1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    cycle();
    idle(); sb_set = 1; sb_set_addr = 5'd0;
    check("t5_x0_no_wren", rd_wren, 0);
    cycle();
    idle(); rs1_addr = 5'd0;
    cycle();

    // Same-cycle set and clear: set wins
    sb_set = 1; sb_set_addr = 5'd5; wb_valid = 1; wb_addr = 5'd5; wb_data = 32'h55;
    cycle();
    idle(); rs1_addr = 5'd5;
    cycle();
    rs1_addr = 5'd5;
    check("t6_x5_still_busy", rs1_busy, 1);
    cycle();

    // Reset while a write is in flight
    wa_valid = 1; wa_addr = 5'd7; wa_data = 32'h77777777;
    cycle();
    idle();
    check("t6_inflight_before_rst", rd_wren, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_state();
    idle();

    // Randomized traffic with frequent address collisions
    for (int n = 0; n < 1500; n++) begin
      wa_valid    = ($urandom_range(0, 9) < 6);
      wa_addr     = 5'($urandom_range(0, 7));
      wa_data     = $urandom;
      wb_valid    = ($urandom_range(0, 9) < 5);
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      sb_set      = ($urandom_range(0, 9) < 2);
      sb_set_addr = 5'($urandom_range(0, 7));
      rs1_addr    = 5'($urandom_range(0, 7));
      rs2_addr    = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
